// File: rtl/ro_bank_meter.sv
`timescale 1ns/1ps
// Ring-oscillator measurement bank: enables one gated ring at a time and counts
// its rising edges over a fixed clk window, reporting each channel over valid/ready.
module ro_bank_meter #(
  parameter int N_CH      = 4,
  parameter int STAGES    = 17,
  parameter int WINDOW    = 1024,
  parameter int SETTLE    = 8,
  parameter int CNT_W     = 16,
  parameter int INV_DELAY = 1,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic [N_CH-1:0]  ch_mask,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CH_W-1:0]  result_ch,
  output logic [CNT_W-1:0] result_count,
  output logic             result_sat
);

  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);

  if ((STAGES % 2) == 0 || STAGES < 3) begin : g_bad_stages
    $error("ro_bank_meter: STAGES must be odd and >= 3");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_REPORT} state_t;

  state_t            state, state_nx;
  logic [N_CH-1:0]   mask_q, mask_nx;
  logic [CH_W-1:0]   ch_q, ch_nx;
  logic [TMR_W-1:0]  timer, timer_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [N_CH-1:0]   ro_en, ro_en_nx;
  logic [N_CH-1:0]   ring_out;
  logic              sync_p0, sync_p1, edge_p2;
  logic              rise;
  logic [CH_W:0]     first_sel, up_sel, wrap_sel;

  // Lowest set bit of m at or above index from; MSB flags that one was found.
  function automatic logic [CH_W:0] lowest_from(input logic [N_CH-1:0] m, input int from);
    logic [CH_W:0] r;
    r = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (m[k] && k >= from) r = {1'b1, CH_W'(k)};
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Each ring: NAND(enable, feedback) then STAGES-1 inverters; idle output is high.
  for (genvar i = 0; i < N_CH; i++) begin : g_ring
    (* keep = "true" *) logic [STAGES-1:0] node;
`ifdef SYNTHESIS
    assign node[0] = ~(ro_en[i] & node[STAGES-1]);
    for (genvar s = 1; s < STAGES; s++) begin : g_inv
      assign node[s] = ~node[s-1];
    end
`else
    assign #(INV_DELAY) node[0] = ~(ro_en[i] & node[STAGES-1]);
    for (genvar s = 1; s < STAGES; s++) begin : g_inv
      assign #(INV_DELAY) node[s] = ~node[s-1];
    end
`endif
    assign ring_out[i] = node[STAGES-1];
  end

  assign rise = sync_p1 & ~edge_p2;

  always_comb begin
    state_nx  = state;
    mask_nx   = mask_q;
    ch_nx     = ch_q;
    timer_nx  = timer;
    cnt_nx    = cnt;
    ro_en_nx  = '0;
    first_sel = lowest_from(ch_mask, 0);
    up_sel    = lowest_from(mask_q, int'(ch_q) + 1);
    wrap_sel  = lowest_from(mask_q, 0);
    unique case (state)
      S_IDLE: begin
        if (start && (|ch_mask)) begin
          mask_nx  = ch_mask;
          ch_nx    = first_sel[CH_W-1:0];
          timer_nx = '0;
          state_nx = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_nx = '0;
        if (timer == SETTLE_LAST) begin
          timer_nx = '0;
          state_nx = S_COUNT;
        end else begin
          timer_nx = timer + TMR_W'(1);
        end
      end
      S_COUNT: begin
        if (rise) cnt_nx = sat_inc(cnt);
        if (timer == WINDOW_LAST) begin
          timer_nx = '0;
          state_nx = S_REPORT;
        end else begin
          timer_nx = timer + TMR_W'(1);
        end
      end
      S_REPORT: begin
        if (result_ready) begin
          timer_nx = '0;
          if (up_sel[CH_W]) begin
            ch_nx    = up_sel[CH_W-1:0];
            state_nx = S_SETTLE;
          end else if (continuous) begin
            ch_nx    = wrap_sel[CH_W-1:0];
            state_nx = S_SETTLE;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (state_nx == S_SETTLE || state_nx == S_COUNT) ro_en_nx = N_CH'(1) << ch_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mask_q <= '0;
      ch_q   <= '0;
      timer  <= '0;
      cnt    <= '0;
      ro_en  <= '0;
    end else begin
      state  <= state_nx;
      mask_q <= mask_nx;
      ch_q   <= ch_nx;
      timer  <= timer_nx;
      cnt    <= cnt_nx;
      ro_en  <= ro_en_nx;
    end
  end

  // Sampling pipeline: p0/p1 synchronise the selected ring, p2 holds the previous sample.
  // It runs continuously so SETTLE (>= 3 cycles) flushes stale data from the prior channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      edge_p2 <= 1'b0;
    end else begin
      sync_p0 <= ring_out[ch_q];
      sync_p1 <= sync_p0;
      edge_p2 <= sync_p1;
    end
  end

  assign busy         = (state != S_IDLE);
  assign result_valid = (state == S_REPORT);
  assign result_ch    = ch_q;
  assign result_count = cnt;
  assign result_sat   = result_valid & (&cnt);

endmodule
